vector_frame_writer: RTL and testbench

VECTOR_FRAME_WRITER -- requirements
Module: vector_frame_writer

---
 rtl/vfw_if.sv | 29 ++
 rtl/vector_frame_writer.sv | 76 +++++++
 tb/tb_vector_frame_writer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vfw_if.sv
// vfw_if: entry stream in, vector-RAM write port and frame status out
interface vfw_if #(
  parameter int OUT_WIDTH    = 8,
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = 18
);
  logic                    go_master;
  logic                    halt;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_draw;
  logic [OUT_WIDTH-1:0]    in_x;
  logic [OUT_WIDTH-1:0]    in_y;
  logic                    in_last;
  logic                    wr_en;
  logic [ADDRESSWIDTH-1:0] wr_addr;
  logic [DATAWIDTH-1:0]    wr_data;
  logic                    wr_bank;
  logic                    frame_pending;
  logic                    overflow;
  modport master (
    output go_master, halt, in_valid, in_draw, in_x, in_y, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, wr_bank, frame_pending, overflow
  );
  modport slave (
    input  go_master, halt, in_valid, in_draw, in_x, in_y, in_last,
    output in_ready, wr_en, wr_addr, wr_data, wr_bank, frame_pending, overflow
  );
endinterface

// File: rtl/vector_frame_writer.sv
// vector_frame_writer: packs draw/move entries into a double-buffered vector RAM frame
module vector_frame_writer #(
  parameter int OUT_WIDTH    = 8,
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = 18,
  parameter int FRAME_MIN    = 0,
  parameter int FRAME_MAX    = 255
) (
  input logic   clk,
  input logic   rst,
  vfw_if.slave  bus
);
  localparam logic [ADDRESSWIDTH-1:0] PMIN = ADDRESSWIDTH'(FRAME_MIN);
  localparam logic [ADDRESSWIDTH-1:0] PMAX = ADDRESSWIDTH'(FRAME_MAX);
  typedef enum logic [1:0] {FILL, TERM, WAIT_SWAP} state_t;
  state_t                  state, state_n;
  logic [ADDRESSWIDTH-1:0] ptr;
  logic                    pend;
  logic [ADDRESSWIDTH-1:0] addr;
  logic [DATAWIDTH-1:0]    data;
  logic                    bank, pending, ovf;
  logic                    go, ready, accept, room;
  assign go = bus.go_master;
  always_ff @(posedge clk)
    if (rst) state <= FILL;
    else state <= state_n;
  always_comb
    state_n = !go ? state :
              state == FILL ? ((accept && bus.in_last) ? TERM : FILL) :
              state == TERM ? WAIT_SWAP :
              (bus.halt ? FILL : WAIT_SWAP);
  always_comb begin
    ready  = !rst && go && state == FILL;
    accept = ready && bus.in_valid;
    room   = ptr != PMAX;
  end
  // The registered write survives a go_master drop and is issued once it returns.
  always_ff @(posedge clk)
    if (rst) begin
      ptr     <= PMIN;
      pend    <= 1'b0;
      addr    <= '0;
      data    <= '0;
      bank    <= 1'b0;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else if (go) begin
      pend <= 1'b0;
      if (accept && room) begin
        pend <= 1'b1;
        addr <= ptr;
        data <= DATAWIDTH'({1'b0, bus.in_draw, bus.in_x, bus.in_y});
        ptr  <= ptr + 1'b1;
      end
      if (accept && !room) ovf <= 1'b1;
      if (state == TERM) begin
        pend    <= 1'b1;
        addr    <= ptr;
        data    <= {2'b10, (DATAWIDTH-2)'(0)};
        pending <= 1'b1;
      end
      if (state == WAIT_SWAP && bus.halt) begin
        bank    <= ~bank;
        ptr     <= PMIN;
        pending <= 1'b0;
        ovf     <= 1'b0;
      end
    end
  assign bus.in_ready      = ready;
  assign bus.wr_en         = pend && go;
  assign bus.wr_addr       = addr;
  assign bus.wr_data       = data;
  assign bus.wr_bank       = bank;
  assign bus.frame_pending = pending;
  assign bus.overflow      = ovf;
endmodule

// File: tb/tb_vector_frame_writer.sv
// tb_vector_frame_writer: directed cycle table plus overflow and reset-in-TERM sequences
module tb_vector_frame_writer;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  always #5 clk = ~clk;
  vfw_if #(.OUT_WIDTH(8), .ADDRESSWIDTH(8), .DATAWIDTH(18)) bus ();
  vector_frame_writer #(
    .OUT_WIDTH(8), .ADDRESSWIDTH(8), .DATAWIDTH(18), .FRAME_MIN(0), .FRAME_MAX(255)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic go, halt, valid, draw, last;
    logic [7:0] x, y;
    logic ready, wen;
    logic [7:0] addr;
    logic [1:0] cmd;
    logic [7:0] ex, ey;
    logic bank, fp, ov;
  } vec_t;
  vec_t tv [24];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic go, halt, valid, draw, last, input logic [7:0] x, y);
    bus.go_master = go;
    bus.halt      = halt;
    bus.in_valid  = valid;
    bus.in_draw   = draw;
    bus.in_last   = last;
    bus.in_x      = x;
    bus.in_y      = y;
  endtask
  initial begin
    tv[0]  = '{1,0,1,0,0,10,20, 1,0,0,0,0,0, 0,0,0};
    tv[1]  = '{1,0,1,1,0,30,40, 1,1,0,0,10,20, 0,0,0};
    tv[2]  = '{1,0,1,1,1,50,60, 1,1,1,1,30,40, 0,0,0};
    tv[3]  = '{1,0,0,0,0,0,0,   0,1,2,1,50,60, 0,0,0};
    tv[4]  = '{1,0,0,0,0,0,0,   0,1,3,2,0,0,   0,1,0};
    tv[5]  = '{1,0,0,0,0,0,0,   0,0,0,0,0,0,   0,1,0};
    tv[6]  = '{1,1,0,0,0,0,0,   0,0,0,0,0,0,   0,1,0};
    tv[7]  = '{1,0,1,0,0,1,1,   1,0,0,0,0,0,   1,0,0};
    tv[8]  = '{1,0,1,1,0,2,2,   1,1,0,0,1,1,   1,0,0};
    tv[9]  = '{1,0,1,1,0,3,3,   1,1,1,1,2,2,   1,0,0};
    tv[10] = '{1,0,1,1,0,4,4,   1,1,2,1,3,3,   1,0,0};
    tv[11] = '{1,0,0,0,0,0,0,   1,1,3,1,4,4,   1,0,0};
    tv[12] = '{1,0,1,1,0,5,5,   1,0,0,0,0,0,   1,0,0};
    tv[13] = '{1,1,0,0,0,0,0,   1,1,4,1,5,5,   1,0,0};
    tv[14] = '{1,0,1,0,0,6,6,   1,0,0,0,0,0,   1,0,0};
    tv[15] = '{0,0,1,1,0,9,9,   0,0,0,0,0,0,   1,0,0};
    tv[16] = '{0,0,0,0,0,0,0,   0,0,0,0,0,0,   1,0,0};
    tv[17] = '{0,0,0,0,0,0,0,   0,0,0,0,0,0,   1,0,0};
    tv[18] = '{1,0,0,0,0,0,0,   1,1,5,0,6,6,   1,0,0};
    tv[19] = '{1,0,1,1,1,7,7,   1,0,0,0,0,0,   1,0,0};
    tv[20] = '{1,1,0,0,0,0,0,   0,1,6,1,7,7,   1,0,0};
    tv[21] = '{1,0,0,0,0,0,0,   0,1,7,2,0,0,   1,1,0};
    tv[22] = '{1,1,0,0,0,0,0,   0,0,0,0,0,0,   1,1,0};
    tv[23] = '{1,0,0,0,0,0,0,   1,0,0,0,0,0,   0,0,0};
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("ready_in_reset", 32'(bus.in_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_wen", 32'(bus.wr_en), 0);
    chk("rst_addr", 32'(bus.wr_addr), 0);
    chk("rst_data", 32'(bus.wr_data), 0);
    chk("rst_bank", 32'(bus.wr_bank), 0);
    chk("rst_fp", 32'(bus.frame_pending), 0);
    chk("rst_ov", 32'(bus.overflow), 0);
    for (int i = 0; i < 24; i++) begin
      drive(tv[i].go, tv[i].halt, tv[i].valid, tv[i].draw, tv[i].last, tv[i].x, tv[i].y);
      #1;
      chk($sformatf("tv%0d_ready", i), 32'(bus.in_ready), 32'(tv[i].ready));
      chk($sformatf("tv%0d_wen", i), 32'(bus.wr_en), 32'(tv[i].wen));
      chk($sformatf("tv%0d_bank", i), 32'(bus.wr_bank), 32'(tv[i].bank));
      chk($sformatf("tv%0d_fp", i), 32'(bus.frame_pending), 32'(tv[i].fp));
      chk($sformatf("tv%0d_ov", i), 32'(bus.overflow), 32'(tv[i].ov));
      if (tv[i].wen) begin
        chk($sformatf("tv%0d_addr", i), 32'(bus.wr_addr), 32'(tv[i].addr));
        chk($sformatf("tv%0d_data", i), 32'(bus.wr_data), 32'({tv[i].cmd, tv[i].ex, tv[i].ey}));
      end
      tick();
    end
    // 260 back-to-back entries into bank 0: 255 written, 5 dropped, terminator at 255
    for (int c = 0; c < 262; c++) begin
      drive(1, 0, c < 260, 1, c == 259, 8'(c), 8'(c + 1));
      #1;
      chk($sformatf("ovf%0d_ready", c), 32'(bus.in_ready), 32'(c <= 259));
      chk($sformatf("ovf%0d_wen", c), 32'(bus.wr_en), 32'((c >= 1 && c <= 255) || c == 261));
      chk($sformatf("ovf%0d_ov", c), 32'(bus.overflow), 32'(c >= 256));
      chk($sformatf("ovf%0d_fp", c), 32'(bus.frame_pending), 32'(c == 261));
      if (c >= 1 && c <= 255) begin
        chk($sformatf("ovf%0d_addr", c), 32'(bus.wr_addr), 32'(c - 1));
        chk($sformatf("ovf%0d_data", c), 32'(bus.wr_data), 32'({2'b01, 8'(c - 1), 8'(c)}));
      end
      if (c == 261) begin
        chk("ovf_term_addr", 32'(bus.wr_addr), 255);
        chk("ovf_term_data", 32'(bus.wr_data), 32'({2'b10, 16'h0}));
        chk("ovf_term_bank", 32'(bus.wr_bank), 0);
      end
      tick();
    end
    drive(1, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("swap_bank", 32'(bus.wr_bank), 1);
    chk("swap_ov_clear", 32'(bus.overflow), 0);
    chk("swap_fp_clear", 32'(bus.frame_pending), 0);
    chk("swap_ready", 32'(bus.in_ready), 1);
    // reset while in TERM abandons the frame
    drive(1, 0, 1, 1, 1, 9, 9);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("term_rst_ready", 32'(bus.in_ready), 0);
    chk("term_last_wen", 32'(bus.wr_en), 1);
    chk("term_last_addr", 32'(bus.wr_addr), 0);
    chk("term_last_data", 32'(bus.wr_data), 32'({2'b01, 8'd9, 8'd9}));
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_wen", 32'(bus.wr_en), 0);
    chk("post_rst_addr", 32'(bus.wr_addr), 0);
    chk("post_rst_data", 32'(bus.wr_data), 0);
    chk("post_rst_bank", 32'(bus.wr_bank), 0);
    chk("post_rst_fp", 32'(bus.frame_pending), 0);
    chk("post_rst_ov", 32'(bus.overflow), 0);
    chk("post_rst_ready", 32'(bus.in_ready), 1);
    tick();
    chk("post_rst_no_term", 32'(bus.wr_en), 0);
    chk("post_rst_fp2", 32'(bus.frame_pending), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
